// File: rtl/clock_pkg.sv
// Shared clock types and limits: edit FSM states, field maxima and a wrap-around step helper.
package clock_pkg;

    typedef enum logic [2:0] {
        RUN   = 3'd0,
        T_HR  = 3'd1,
        T_MIN = 3'd2,
        T_SEC = 3'd3,
        A_HR  = 3'd4,
        A_MIN = 3'd5,
        A_EN  = 3'd6
    } edit_state_e;

    localparam logic [4:0] HR_MAX = 5'd23;
    localparam logic [5:0] MS_MAX = 6'd59;

    // +1/-1 with wrap between 0 and max; hour values are zero-extended by the caller.
    function automatic logic [5:0] wrap_step(input logic [5:0] val, input logic [5:0] max,
                                             input logic up);
        logic [5:0] res;
        if (up) res = (val >= max) ? 6'd0 : val + 6'd1;
        else    res = (val == 6'd0) ? max : val - 6'd1;
        return res;
    endfunction

endpackage

// File: rtl/btn_rpt.sv
// Rising-edge detector with hold-to-repeat: one step on the press, one after RPT_DELAY
// cycles of hold, then one every RPT_PERIOD cycles until release.
module btn_rpt #(
    parameter int RPT_DELAY  = 8,
    parameter int RPT_PERIOD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press,
    output logic step
);

    localparam int CW = $clog2((RPT_DELAY > RPT_PERIOD ? RPT_DELAY : RPT_PERIOD) + 1);

    logic          btn_q;
    logic [CW-1:0] cnt;
    logic          rpt;

    assign press = btn & ~btn_q;
    assign rpt   = btn & btn_q & (cnt == '0);
    assign step  = press | rpt;

    // cnt holds the cycles left until the next repeat step while the button is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q <= 1'b0;
            cnt   <= '0;
        end else begin
            btn_q <= btn;
            if (press)    cnt <= CW'(RPT_DELAY - 1);
            else if (rpt) cnt <= CW'(RPT_PERIOD - 1);
            else if (btn) cnt <= cnt - 1'b1;
            else          cnt <= '0;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Button-driven time/alarm setting FSM: snapshots the live time, edits one field per
// state, commits with a one-cycle load strobe, and abandons idle sessions on timeout.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_SEC = 30,
    parameter int RPT_DELAY   = 8,
    parameter int RPT_PERIOD  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_ok,
    input  logic [4:0] cur_hr,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] hr_in,
    output logic [5:0] min_in,
    output logic [5:0] sec_in,
    output logic       set_time,
    output logic [4:0] alarm_hr_in,
    output logic [5:0] alarm_min_in,
    output logic       set_alarm,
    output logic       alarm_en_in,
    output logic [2:0] edit_state,
    output logic       blink
);

    localparam int TW = $clog2(TIMEOUT_SEC + 1);

    edit_state_e   state;
    logic          mode_q, ok_q;
    logic          mode_press, ok_press;
    logic          inc_press, inc_step, dec_press, dec_step;
    logic          inc_act, dec_act, any_press, timeout;
    logic [4:0]    e_hr, a_hr;
    logic [5:0]    e_min, e_sec, a_min;
    logic          a_en;
    logic [TW-1:0] to_cnt;

    btn_rpt #(.RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)) u_inc (
        .clk(clk), .rst_n(rst_n), .btn(btn_inc), .press(inc_press), .step(inc_step)
    );

    btn_rpt #(.RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)) u_dec (
        .clk(clk), .rst_n(rst_n), .btn(btn_dec), .press(dec_press), .step(dec_step)
    );

    assign mode_press = btn_mode & ~mode_q;
    assign ok_press   = btn_ok & ~ok_q;
    assign any_press  = mode_press | ok_press | inc_press | dec_press;
    // The opposite button being high at all (pressed or held) cancels the step.
    assign inc_act    = inc_step & ~btn_dec;
    assign dec_act    = dec_step & ~btn_inc;
    assign timeout    = tick_1hz & ~any_press & (to_cnt == TW'(TIMEOUT_SEC - 1));
    assign edit_state = state;

    // NOTE: every register, including the edit copies, is cleared by the async reset so a
    // session interrupted by reset can never leak stale values into a later commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            mode_q       <= 1'b0;
            ok_q         <= 1'b0;
            e_hr         <= '0;
            e_min        <= '0;
            e_sec        <= '0;
            a_hr         <= '0;
            a_min        <= '0;
            a_en         <= 1'b0;
            to_cnt       <= '0;
            hr_in        <= '0;
            min_in       <= '0;
            sec_in       <= '0;
            set_time     <= 1'b0;
            alarm_hr_in  <= '0;
            alarm_min_in <= '0;
            alarm_en_in  <= 1'b0;
            set_alarm    <= 1'b0;
            blink        <= 1'b0;
        end else begin
            mode_q    <= btn_mode;
            ok_q      <= btn_ok;
            set_time  <= 1'b0;
            set_alarm <= 1'b0;

            if (state == RUN) begin
                blink  <= 1'b0;
                to_cnt <= '0;
                if (mode_press) begin
                    state <= T_HR;
                    e_hr  <= cur_hr;
                    e_min <= cur_min;
                    e_sec <= cur_sec;
                end
            end else begin
                if (any_press)     to_cnt <= '0;
                else if (tick_1hz) to_cnt <= to_cnt + 1'b1;
                if (tick_1hz)      blink  <= ~blink;

                if (ok_press) begin
                    if (state == T_HR || state == T_MIN || state == T_SEC) begin
                        hr_in    <= e_hr;
                        min_in   <= e_min;
                        sec_in   <= e_sec;
                        set_time <= 1'b1;
                    end else begin
                        alarm_hr_in  <= a_hr;
                        alarm_min_in <= a_min;
                        alarm_en_in  <= a_en;
                        set_alarm    <= 1'b1;
                    end
                    state <= RUN;
                    blink <= 1'b0;
                end else if (mode_press) begin
                    case (state)
                        T_HR:    state <= T_MIN;
                        T_MIN:   state <= T_SEC;
                        T_SEC: begin
                            state <= A_HR;
                            a_hr  <= alarm_hr_in;
                            a_min <= alarm_min_in;
                            a_en  <= alarm_en_in;
                        end
                        A_HR:    state <= A_MIN;
                        A_MIN:   state <= A_EN;
                        default: begin
                            state <= RUN;
                            blink <= 1'b0;
                        end
                    endcase
                end else if (timeout) begin
                    state <= RUN;
                    blink <= 1'b0;
                end else if (inc_act || dec_act) begin
                    case (state)
                        T_HR:    e_hr  <= 5'(wrap_step({1'b0, e_hr}, {1'b0, HR_MAX}, inc_act));
                        T_MIN:   e_min <= wrap_step(e_min, MS_MAX, inc_act);
                        T_SEC:   e_sec <= wrap_step(e_sec, MS_MAX, inc_act);
                        A_HR:    a_hr  <= 5'(wrap_step({1'b0, a_hr}, {1'b0, HR_MAX}, inc_act));
                        A_MIN:   a_min <= wrap_step(a_min, MS_MAX, inc_act);
                        default: a_en  <= ~a_en;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl: stimulus pushes expected load strobes into a queue,
// a negedge monitor pops and compares them whenever set_time or set_alarm fires.
module tb_clock_set_ctrl;
    import clock_pkg::*;

    localparam int TIMEOUT_SEC = 30;
    localparam int RPT_DELAY   = 8;
    localparam int RPT_PERIOD  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_ok = 1'b0;
    logic [4:0] cur_hr = '0;
    logic [5:0] cur_min = '0, cur_sec = '0;
    logic [4:0] hr_in, alarm_hr_in;
    logic [5:0] min_in, sec_in, alarm_min_in;
    logic       set_time, set_alarm, alarm_en_in, blink;
    logic [2:0] edit_state;

    typedef struct {
        logic       is_alarm;
        logic [4:0] hr;
        logic [5:0] min;
        logic [5:0] sec_or_en;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    clock_set_ctrl #(.TIMEOUT_SEC(TIMEOUT_SEC), .RPT_DELAY(RPT_DELAY), .RPT_PERIOD(RPT_PERIOD)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_ok(btn_ok),
        .cur_hr(cur_hr), .cur_min(cur_min), .cur_sec(cur_sec),
        .hr_in(hr_in), .min_in(min_in), .sec_in(sec_in), .set_time(set_time),
        .alarm_hr_in(alarm_hr_in), .alarm_min_in(alarm_min_in), .set_alarm(set_alarm),
        .alarm_en_in(alarm_en_in), .edit_state(edit_state), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && (set_time || set_alarm)) begin
            check("strobe_exclusive", 32'(set_time & set_alarm), 0);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'({set_time, set_alarm}), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_kind", 32'(set_alarm), 32'(e.is_alarm));
                if (e.is_alarm) begin
                    check("alarm_hr_in", 32'(alarm_hr_in), 32'(e.hr));
                    check("alarm_min_in", 32'(alarm_min_in), 32'(e.min));
                    check("alarm_en_in", 32'(alarm_en_in), 32'(e.sec_or_en));
                end else begin
                    check("hr_in", 32'(hr_in), 32'(e.hr));
                    check("min_in", 32'(min_in), 32'(e.min));
                    check("sec_in", 32'(sec_in), 32'(e.sec_or_en));
                end
            end
        end
    end

    task automatic expect_time(input int h, input int m, input int s);
        sb.push_back('{1'b0, 5'(h), 6'(m), 6'(s)});
    endtask

    task automatic expect_alarm(input int h, input int m, input int en);
        sb.push_back('{1'b1, 5'(h), 6'(m), 6'(en)});
    endtask

    task automatic press(input logic m, input logic i, input logic d, input logic o);
        @(negedge clk);
        btn_mode = m; btn_inc = i; btn_dec = d; btn_ok = o;
        @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0; btn_ok = 1'b0;
        @(negedge clk);
    endtask

    task automatic tick_pulse();
        @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    task automatic enter_edit(input int h, input int m, input int s);
        cur_hr = 5'(h); cur_min = 6'(m); cur_sec = 6'(s);
        press(1, 0, 0, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset_state", 32'(edit_state), 32'(RUN));
        check("reset_outputs", 32'({hr_in, min_in, sec_in, alarm_hr_in, alarm_min_in,
                                    alarm_en_in, set_time, set_alarm, blink}), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Snapshot 10:20:30, three increments of the hour, commit.
        enter_edit(10, 20, 30);
        check("snapshot_state", 32'(edit_state), 32'(T_HR));
        repeat (3) press(0, 1, 0, 0);
        expect_time(13, 20, 30);
        press(0, 0, 0, 1);
        check("commit_state", 32'(edit_state), 32'(RUN));

        // Wrap: hour 0 -> 23 on dec, minute 59 -> 0 on inc.
        enter_edit(0, 59, 0);
        press(0, 0, 1, 0);
        press(1, 0, 0, 0);
        check("t_min_state", 32'(edit_state), 32'(T_MIN));
        press(0, 1, 0, 0);
        expect_time(23, 0, 0);
        press(0, 0, 0, 1);

        // ok wins over a simultaneous mode press.
        enter_edit(5, 6, 7);
        expect_time(5, 6, 7);
        press(1, 0, 0, 1);
        check("ok_priority_state", 32'(edit_state), 32'(RUN));

        // inc together with ok is ignored.
        enter_edit(1, 2, 3);
        expect_time(1, 2, 3);
        press(0, 1, 0, 1);

        // inc and dec pressed together change nothing.
        enter_edit(4, 0, 0);
        press(0, 1, 1, 0);
        expect_time(4, 0, 0);
        press(0, 0, 0, 1);

        // ok in RUN does nothing.
        press(0, 0, 0, 1);
        check("ok_in_run_state", 32'(edit_state), 32'(RUN));

        // Alarm: hour 6, minute 1, enable on.
        repeat (4) press(1, 0, 0, 0);
        check("a_hr_state", 32'(edit_state), 32'(A_HR));
        repeat (6) press(0, 1, 0, 0);
        press(1, 0, 0, 0);
        press(0, 1, 0, 0);
        press(1, 0, 0, 0);
        check("a_en_state", 32'(edit_state), 32'(A_EN));
        press(0, 1, 0, 0);
        expect_alarm(6, 1, 1);
        press(0, 0, 0, 1);
        check("alarm_commit_state", 32'(edit_state), 32'(RUN));

        // Blink and timeout, with a press after tick 29 restarting the count.
        enter_edit(2, 2, 2);
        check("blink_enter", 32'(blink), 0);
        tick_pulse();
        check("blink_tick1", 32'(blink), 1);
        for (int k = 1; k < TIMEOUT_SEC - 1; k++) tick_pulse();
        check("timeout_not_yet", 32'(edit_state), 32'(T_HR));
        check("blink_tick29", 32'(blink), 1);
        press(0, 1, 0, 0);
        for (int k = 0; k < TIMEOUT_SEC - 1; k++) tick_pulse();
        check("timeout_restarted", 32'(edit_state), 32'(T_HR));
        tick_pulse();
        @(negedge clk);
        check("timeout_state", 32'(edit_state), 32'(RUN));
        check("timeout_blink", 32'(blink), 0);

        // Auto-repeat: press edge plus 28 held cycles in T_SEC from 0 gives 7 steps.
        enter_edit(0, 0, 0);
        repeat (2) press(1, 0, 0, 0);
        check("t_sec_state", 32'(edit_state), 32'(T_SEC));
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (RPT_DELAY + 5 * RPT_PERIOD + 1) @(posedge clk);
        @(negedge clk);
        btn_inc = 1'b0;
        expect_time(0, 0, 7);
        press(0, 0, 0, 1);

        // Reset mid-session in T_MIN.
        enter_edit(9, 9, 9);
        press(1, 0, 0, 0);
        check("pre_reset_state", 32'(edit_state), 32'(T_MIN));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_reset_state", 32'(edit_state), 32'(RUN));
        check("mid_reset_outputs", 32'({hr_in, min_in, sec_in, alarm_hr_in, alarm_min_in,
                                        alarm_en_in, set_time, set_alarm, blink}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_reset_state", 32'(edit_state), 32'(RUN));

        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_set_ctrl.md
CLOCK_SET_CTRL -- requirements
Module: clock_set_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_SEC, default 30: number of idle tick_1hz pulses before an edit session is abandoned.
REQ-002 SHALL have parameter RPT_DELAY, default 8: clk cycles a held inc/dec must persist before auto-repeat starts.
REQ-003 SHALL have parameter RPT_PERIOD, default 4: clk cycles between auto-repeat steps.
REQ-004 SHALL have ports, one per line:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- tick_1hz  in  1  one-cycle pulse, once per second, from the clock tick generator.
- btn_mode, btn_inc, btn_dec, btn_ok  in  1 each  debounced, clk-synchronous button levels.
- cur_hr  in  5  live hour, 0-23.
- cur_min, cur_sec  in  6 each  live minute and second, 0-59.
- hr_in  out  5  time load value for the hour counter.
- min_in, sec_in  out  6 each  time load values for the minute and second counters.
- set_time  out  1  one-cycle time load strobe.
- alarm_hr_in  out  5  alarm hour.
- alarm_min_in  out  6  alarm minute.
- set_alarm  out  1  one-cycle alarm load strobe.
- alarm_en_in  out  1  alarm enable level.
- edit_state  out  3  current FSM state encoding.
- blink  out  1  display blink for the field being edited.

Function
REQ-005 SHALL register a press on the rising edge of each button level; the resulting action is visible one cycle after the edge.
REQ-006 SHALL implement the states RUN, T_HR, T_MIN, T_SEC, A_HR, A_MIN, A_EN.
REQ-007 SHALL advance on btn_mode press in the order RUN>T_HR>T_MIN>T_SEC>A_HR>A_MIN>A_EN>RUN, without committing any edit.
REQ-008 SHALL, on RUN>T_HR, copy cur_hr, cur_min and cur_sec into the edit registers in the same cycle.
REQ-009 SHALL, on T_SEC>A_HR, copy the committed alarm_hr_in, alarm_min_in and alarm_en_in values into the alarm edit registers.
REQ-010 SHALL, on an inc/dec press, change only the field selected by the state by +1/-1, with wrap: hour 23<->0, minute/second 59<->0; in A_EN, inc or dec toggles the edit enable bit.
REQ-011 SHALL treat simultaneous inc and dec presses, or both held, as no change.
REQ-012 SHALL, while inc or dec is held alone, apply one step on the edge, then a step after RPT_DELAY cycles, then one step every RPT_PERIOD cycles until release.
REQ-013 SHALL, on a btn_ok press in T_*, drive hr_in/min_in/sec_in with the edit values, pulse set_time for exactly one cycle, and go to RUN.
REQ-014 SHALL, on a btn_ok press in A_*, update alarm_hr_in, alarm_min_in and alarm_en_in, pulse set_alarm for exactly one cycle, and go to RUN.
REQ-015 SHALL ignore btn_ok in RUN.
REQ-016 SHALL give btn_ok priority when mode and ok are pressed in the same cycle.
REQ-017 SHALL ignore inc/dec in a cycle with an ok or mode press.
REQ-018 SHALL, in any edit state, return to RUN without any strobe after TIMEOUT_SEC tick_1hz pulses with no press; any press restarts the count.
REQ-019 SHALL toggle blink on each tick_1hz while in an edit state, and force blink to 0 in RUN.
REQ-020 SHALL never assert set_time and set_alarm in the same cycle.

Reset
REQ-021 SHALL, on rst_n low, asynchronously force:
- state RUN
- all data outputs and edit registers 0
- set_time, set_alarm, blink 0
- alarm_en_in 0
- repeat and timeout counters 0
REQ-022 SHALL discard any in-progress edit without a strobe when reset is asserted mid-session.

Structure
REQ-023 SHALL take the state enum, HR_MAX=23 and MS_MAX=59 from the shared package clock_pkg.
REQ-024 SHALL implement edge detection plus auto-repeat in sub-module btn_rpt, instantiated once for inc and once for dec.

Verification
REQ-025 Snapshot and commit: cur 10:20:30, mode, inc x3, ok -> set_time pulses once with hr_in=13, min_in=20, sec_in=30; state RUN.
REQ-026 Wrap: in T_MIN at 59, inc -> 0; in T_HR at 0, dec -> 23.
REQ-027 Alarm: mode x4, inc x6, mode, inc, mode, inc, ok -> set_alarm pulses once with alarm_hr_in=6, alarm_min_in=1, alarm_en_in=1; set_time stays 0.
REQ-028 Timeout: enter T_HR, 30 tick_1hz pulses with no press -> RUN, no strobe; a press at tick 29 restarts the count.
REQ-029 Auto-repeat: hold inc for 8+4*5 cycles in T_SEC starting at 0 -> sec edit value = 7.
REQ-030 Reset: rst_n low mid-T_MIN -> RUN, all outputs 0, no strobe.
